i2s_adc_receiver: RTL and testbench
===================================

Name: i2s_adc_receiver

Overview:
- Receive-side counterpart of the audioController DAC path: deserializes the WM8731 ADC I2S stream (BCLK, ADC_LR_CLK, ADC_DATA) into parallel left/right sample pairs.
- Codec pins are oversampled in the 50 MHz clk domain; completed stereo frames are delivered through a valid/ready handshake to downstream DSP or mixer logic.

Parameters:
- SAMPLE_W, 24, bits captured per channel, MSB first; must be 1..32.
- SYNC_STAGES, 2, synchronizer depth applied identically to BCLK, ADC_LR_CLK and ADC_DATA; must be >= 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- BCLK  input  1  codec bit clock, asynchronous to clk, at most clk/8.
- ADC_LR_CLK  input  1  codec ADC word clock: low = left channel, high = right channel.
- ADC_DATA  input  1  codec serial ADC data.
- sample_left  output  SAMPLE_W  left sample, two's complement.
- sample_right  output  SAMPLE_W  right sample, two's complement.
- sample_valid  output  1  sample pair available.
- sample_ready  input  1  consumer accepts the pair.
- overrun  output  1  sticky: a pair was dropped because the output was still held.
- frame_err  output  1  sticky: an LR edge arrived before SAMPLE_W bits were captured.

Behaviour:
- Reset (reset == 0 at a clk edge): all outputs 0, FSM to IDLE, synchronizers and shift register cleared, bit counter 0. A reset applied mid-frame discards the partial frame and any held pair.
- Synchronization and edge detection:
  - All three pins pass through SYNC_STAGES flops, plus one extra delay flop used for edge detection.
  - bclk_rise = sync high and delayed low. lr_edge = any change of the synchronized LR.
  - Every event below is qualified by bclk_rise; LR is sampled only on bclk_rise.
- I2S framing:
  - An LR transition is detected on a BCLK rise.
  - The MSB is on the next BCLK rise (one-bit delay).
  - SAMPLE_W bits follow; any further bits before the next LR transition are ignored.
- FSM states: IDLE, ALIGN, SHIFT, DRAIN.
  - IDLE: wait for the first lr_edge, then go to ALIGN. The current channel is the new LR level.
  - ALIGN: on bclk_rise go to SHIFT; that rise captures the MSB, and the bit count becomes 1.
  - SHIFT: on each bclk_rise, shift ADC_DATA into the LSB. When SAMPLE_W bits are captured, commit the channel and go to DRAIN.
  - DRAIN: ignore data; go to ALIGN on lr_edge.
  - lr_edge while in SHIFT (fewer than SAMPLE_W bits): set frame_err, discard the partial word, go to ALIGN. A left word is not committed; a stored left word is invalidated if it was the right word that was cut short.
  - The commit and the lr_edge fall on distinct bclk_rise events and never coincide.
- Pairing:
  - The left word goes into a staging register.
  - When the right word commits while the staged left is valid, the pair is offered.
  - A right word with no staged left (startup case) is discarded silently.
- Output handshake:
  - If sample_valid == 0, or sample_valid && sample_ready in the same cycle: load sample_left/right and set sample_valid = 1 on the cycle after the commit.
  - Otherwise drop the new pair, keep the held pair unchanged, and set overrun.
  - sample_valid && sample_ready with no new pair clears sample_valid the next cycle.
- Latency: sample_valid rises SYNC_STAGES + 2 clk cycles after the clk edge at which raw BCLK first reads high for the right-channel LSB (4 cycles with the default).
- overrun and frame_err clear only on reset.

Optional Feature:
- Macro: ADC_PEAK_METER_EN.
- When defined, add outputs peak_left and peak_right (SAMPLE_W-1 bits each) and input peak_clear.
  - Each accepted pair updates peak = max(peak, |sample|).
  - |-2^(SAMPLE_W-1)| saturates to 2^(SAMPLE_W-1)-1.
  - peak_clear zeroes both peaks next cycle and takes priority over a simultaneous update.
  - Reset value is 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package audio_pkg holds:
  - typedef enum of the FSM states;
  - constant DEFAULT_SAMPLE_W = 24;
  - typedef sample_t as logic signed [DEFAULT_SAMPLE_W-1:0].
- One sub-module, pin_sync: a parameterized SYNC_STAGES synchronizer plus edge flop, instantiated three times.

Test Plan:
- Reset with BCLK toggling → all outputs 0 and no sample_valid until the first full L/R frame after the first LR edge.
- sample_ready held 1; send 24-bit left 24'h7FFFFF, right 24'h800001 (BCLK = clk/16, 32 BCLK per channel) → sample_left = 24'h7FFFFF, sample_right = 24'h800001, one-cycle valid pulse 4 clks after the right LSB BCLK rise, frame_err = 0.
- sample_ready held 0 across two frames (0x000001/0x000002, then 0x000003/0x000004) → outputs hold 1/2, overrun = 1. Raising sample_ready clears sample_valid next cycle.
- Toggle LR after only 10 bits of a left word → frame_err = 1, and the next complete frame 0x123456/0x654321 is delivered correctly.
- Assert reset mid-right-word, release, send 0x00000A/0x00000B → only the A/B pair appears, with flags 0.
- With ADC_PEAK_METER_EN: frames left -5, then +3, then -2^23 → peak_left = 5, then 5, then 0x7FFFFF. peak_clear → 0.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: types and constants shared by the I2S ADC receive path.
// Holds the receiver FSM state type and the default sample width/type.
package audio_pkg;

  localparam int DEFAULT_SAMPLE_W = 24;

  typedef logic signed [DEFAULT_SAMPLE_W-1:0] sample_t;

  // Receiver framing states:
  //   IDLE  - waiting for the first word-clock edge after reset
  //   ALIGN - LR edge seen, the next BCLK rise carries the MSB
  //   SHIFT - capturing bits MSB first
  //   DRAIN - word complete, ignoring padding bits until the next LR edge
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } rx_state_t;

endpackage

// File: rtl/pin_sync.sv
// pin_sync: multi-flop synchronizer for one asynchronous codec pin, plus
// an edge-detect flop holding the synchronized level from the last cycle
// in which en was high. With en tied high, sync & ~prev is a rising edge.
module pin_sync
  import audio_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic en,
  output logic sync,
  output logic prev
);

  logic [STAGES-1:0] chain;

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
    end
  end

  assign sync = chain[STAGES-1];

  // Remember the synchronized level for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev <= 1'b0;
    end else if (en) begin
      prev <= sync;
    end
  end

endmodule

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver: deserializes the WM8731 ADC I2S stream (BCLK,
// ADC_LR_CLK, ADC_DATA) into left/right sample pairs in the clk domain.
//
// Pipeline after the synchronized BCLK rise becomes visible:
//   edge +1 : framing FSM captures the bit / commits the word
//   edge +2 : left word staged, or left+right pair formed
//   edge +3 : pair loaded into the output register (or dropped -> overrun)
//
// Optional build macro: ADC_PEAK_METER_EN adds peak_left/peak_right
// magnitude meters and the peak_clear input.
//
// Output handshake: a pair is transferred on every clk edge where
// sample_valid && sample_ready. While sample_valid is high and
// sample_ready is low, sample_left/sample_right hold steady; a new pair
// arriving in that state is dropped and overrun is set (sticky).
module i2s_adc_receiver
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = DEFAULT_SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                BCLK,
  input  logic                ADC_LR_CLK,
  input  logic                ADC_DATA,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                frame_err
`ifdef ADC_PEAK_METER_EN
  ,
  output logic [SAMPLE_W-2:0] peak_left,
  output logic [SAMPLE_W-2:0] peak_right,
  input  logic                peak_clear
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  // ---------------------------------------------------------------
  // Pin synchronization and edge detection
  // ---------------------------------------------------------------
  logic bclk_sync, bclk_prev;
  logic lr_sync, lr_prev;
  logic data_sync, data_prev;
  logic bclk_rise, lr_edge;

  pin_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (BCLK),
    .en    (1'b1),
    .sync  (bclk_sync),
    .prev  (bclk_prev)
  );

  // LR is only looked at on BCLK rises, so its edge flop advances only then;
  // lr_edge therefore compares against the level seen at the previous rise.
  pin_sync #(.STAGES(SYNC_STAGES)) u_lr_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ADC_LR_CLK),
    .en    (bclk_rise),
    .sync  (lr_sync),
    .prev  (lr_prev)
  );

  // Data shares the BCLK synchronizer depth so bits line up with bclk_rise.
  pin_sync #(.STAGES(SYNC_STAGES)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ADC_DATA),
    .en    (1'b1),
    .sync  (data_sync),
    .prev  (data_prev)
  );

  logic unused_data_prev;
  assign unused_data_prev = data_prev;

  assign bclk_rise = bclk_sync & ~bclk_prev;
  assign lr_edge   = bclk_rise & (lr_sync ^ lr_prev);

  // ---------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------
  rx_state_t state, state_next;

  logic                capture;     // shift data_sync into the word
  logic                first_bit;   // this capture is the MSB
  logic                take_chan;   // latch new LR level as current channel
  logic                word_commit; // last bit captured this cycle
  logic                word_abort;  // LR edge cut a word short

  logic [SAMPLE_W-1:0] shift_reg;
  logic [SAMPLE_W:0]   shift_ext;
  logic [CNT_W-1:0]    bit_cnt;
  logic                chan;        // 0 = left, 1 = right
  logic                word_done;
  logic                word_chan;
  logic                abort_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    first_bit   = 1'b0;
    take_chan   = 1'b0;
    word_commit = 1'b0;
    word_abort  = 1'b0;
    unique case (state)
      IDLE: begin
        if (lr_edge) begin
          take_chan  = 1'b1;
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        if (bclk_rise) begin
          capture   = 1'b1;
          first_bit = 1'b1;
          if (SAMPLE_W == 1) begin
            word_commit = 1'b1;
            state_next  = DRAIN;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (lr_edge) begin
          word_abort = 1'b1;
          take_chan  = 1'b1;
          state_next = ALIGN;
        end else if (bclk_rise) begin
          capture = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            word_commit = 1'b1;
            state_next  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (lr_edge) begin
          take_chan  = 1'b1;
          state_next = ALIGN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign shift_ext = {shift_reg, data_sync};

  // Shift register, bit counter, channel tracking and frame error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      chan      <= 1'b0;
      word_done <= 1'b0;
      word_chan <= 1'b0;
      abort_q   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      word_done <= word_commit;
      word_chan <= chan;
      abort_q   <= word_abort;
      if (capture) begin
        shift_reg <= shift_ext[SAMPLE_W-1:0];
        bit_cnt   <= first_bit ? CNT_W'(1) : bit_cnt + CNT_W'(1);
      end
      if (take_chan) begin
        chan    <= lr_sync;
        bit_cnt <= '0;
      end
      if (word_abort) begin
        frame_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Left staging and pair formation
  // ---------------------------------------------------------------
  logic [SAMPLE_W-1:0] left_stage;
  logic                left_valid;
  logic [SAMPLE_W-1:0] pair_left;
  logic [SAMPLE_W-1:0] pair_right;
  logic                pair_new;

  // Stage left words; a right word completes a pair only if a left is staged.
  // Any aborted word also drops the staged left so a pair never straddles
  // a framing glitch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      left_stage <= '0;
      left_valid <= 1'b0;
      pair_left  <= '0;
      pair_right <= '0;
      pair_new   <= 1'b0;
    end else begin
      pair_new <= 1'b0;
      if (word_done && !word_chan) begin
        left_stage <= shift_reg;
        left_valid <= 1'b1;
      end else if (word_done && word_chan && left_valid) begin
        pair_left  <= left_stage;
        pair_right <= shift_reg;
        pair_new   <= 1'b1;
        left_valid <= 1'b0;
      end else if (abort_q) begin
        left_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------
  logic load_ok;
  assign load_ok = !sample_valid || sample_ready;

  // Load a new pair when the output slot is free or being drained this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (pair_new) begin
        if (load_ok) begin
          sample_left  <= pair_left;
          sample_right <= pair_right;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

`ifdef ADC_PEAK_METER_EN
  // ---------------------------------------------------------------
  // Peak meters
  // ---------------------------------------------------------------
  // Magnitude of a two's complement sample; the most negative value
  // saturates to the largest positive magnitude.
  function automatic logic [SAMPLE_W-2:0] magnitude(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = -s;
    if (!s[SAMPLE_W-1]) begin
      return s[SAMPLE_W-2:0];
    end else if (s[SAMPLE_W-2:0] == '0) begin
      return '1;
    end else begin
      return neg[SAMPLE_W-2:0];
    end
  endfunction

  logic [SAMPLE_W-2:0] mag_left, mag_right;
  assign mag_left  = magnitude(pair_left);
  assign mag_right = magnitude(pair_right);

  // Track the largest magnitude of accepted pairs; clear wins over update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (peak_clear) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (pair_new && load_ok) begin
      if (mag_left > peak_left) begin
        peak_left <= mag_left;
      end
      if (mag_right > peak_right) begin
        peak_right <= mag_right;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb_i2s_adc_receiver: directed I2S frames with hand-computed pairs pushed
// into an expected queue; a monitor pops and compares on each handshake.
// Build with ADC_PEAK_METER_EN defined to also exercise the peak meters.
module tb_i2s_adc_receiver;
  import audio_pkg::*;

  localparam int W    = DEFAULT_SAMPLE_W;
  localparam int HALF = 8;   // clk cycles per BCLK half period (BCLK = clk/16)
  localparam int SLOTS = 32; // BCLK periods per channel

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic BCLK, ADC_LR_CLK, ADC_DATA;
  logic [W-1:0] sample_left, sample_right;
  logic sample_valid, sample_ready;
  logic overrun, frame_err;
`ifdef ADC_PEAK_METER_EN
  logic [W-2:0] peak_left, peak_right;
  logic peak_clear;
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_adc_receiver #(.SAMPLE_W(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .BCLK         (BCLK),
    .ADC_LR_CLK   (ADC_LR_CLK),
    .ADC_DATA     (ADC_DATA),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err)
`ifdef ADC_PEAK_METER_EN
    ,
    .peak_left    (peak_left),
    .peak_right   (peak_right),
    .peak_clear   (peak_clear)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];
  logic chk_clear  = 1'b0;
  logic prev_valid = 1'b0;
  logic lat_armed  = 1'b0;
  int   exp_rise_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One BCLK period: LR and data change while BCLK is low, sampled on the rise.
  task automatic send_slot(input logic lr, input logic bit_val, input logic mark);
    BCLK       = 1'b0;
    ADC_LR_CLK = lr;
    ADC_DATA   = bit_val;
    repeat (HALF) @(negedge clk);
    BCLK = 1'b1;
    if (mark) exp_rise_cyc = cyc + 1 + 4;
    repeat (HALF) @(negedge clk);
  endtask

  // One channel: slot 0 carries the LR edge, slots 1..W carry MSB..LSB.
  task automatic send_channel(input logic lr, input logic [W-1:0] word,
                              input int nslots, input logic mark_lsb);
    for (int k = 0; k < nslots; k++) begin
      logic b;
      b = (k >= 1 && k <= W) ? word[W-k] : 1'b0;
      send_slot(lr, b, mark_lsb && (k == W));
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input logic push, input logic mark);
    if (push) exp_q.push_back({l, r});
    send_channel(1'b0, l, SLOTS, 1'b0);
    send_channel(1'b1, r, SLOTS, mark);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    if (chk_clear) begin
      check("valid_clear_after_accept", 64'(sample_valid), 64'd0);
      chk_clear = 1'b0;
    end
    if (sample_valid && !prev_valid && lat_armed) begin
      check("valid_latency_cycle", 64'(cyc), 64'(exp_rise_cyc));
      lat_armed = 1'b0;
    end
    prev_valid = sample_valid;
    if (sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pair: got %0h_%0h expected none", sample_left, sample_right);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("pair", 64'({sample_left, sample_right}), 64'(e));
      end
      chk_clear = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b0;
    BCLK         = 1'b0;
    ADC_LR_CLK   = 1'b0;
    ADC_DATA     = 1'b0;
    sample_ready = 1'b1;
`ifdef ADC_PEAK_METER_EN
    peak_clear   = 1'b0;
`endif
    @(negedge clk);

    // Reset with BCLK toggling.
    for (int i = 0; i < 4; i++) send_slot(1'b0, 1'b1, 1'b0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_left", 64'(sample_left), 64'd0);
    check("rst_right", 64'(sample_right), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Startup: a right word with no staged left must not appear.
    send_channel(1'b1, 24'h5A5A5A, SLOTS, 1'b0);

    // Full-scale pair with ready held high, latency checked.
    lat_armed = 1'b1;
    send_frame(24'h7FFFFF, 24'h800001, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    check("t1_lat_seen", 64'(lat_armed), 64'd0);
    check("t1_frame_err", 64'(frame_err), 64'd0);
    check("t1_overrun", 64'(overrun), 64'd0);

    // Back-pressure: second pair dropped, first held.
    sample_ready = 1'b0;
    send_frame(24'h000001, 24'h000002, 1'b1, 1'b0);
    send_frame(24'h000003, 24'h000004, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("t2_valid_held", 64'(sample_valid), 64'd1);
    check("t2_left_held", 64'(sample_left), 64'h000001);
    check("t2_right_held", 64'(sample_right), 64'h000002);
    check("t2_overrun", 64'(overrun), 64'd1);
    sample_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Left word cut after 10 bits, then a discarded right, then a good frame.
    send_channel(1'b0, 24'hFFFFFF, 11, 1'b0);
    send_channel(1'b1, 24'hABCDEF, SLOTS, 1'b0);
    send_frame(24'h123456, 24'h654321, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("t3_frame_err", 64'(frame_err), 64'd1);

    // Reset in the middle of a right word.
    send_channel(1'b0, 24'h111111, SLOTS, 1'b0);
    send_channel(1'b1, 24'h222222, 12, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_rst_valid", 64'(sample_valid), 64'd0);
    check("t4_rst_overrun", 64'(overrun), 64'd0);
    check("t4_rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    send_channel(1'b1, 24'h000000, SLOTS, 1'b0);
    send_frame(24'h00000A, 24'h00000B, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("t4_overrun", 64'(overrun), 64'd0);
    check("t4_frame_err", 64'(frame_err), 64'd0);

`ifdef ADC_PEAK_METER_EN
    // Peak meter: -5, +3, most negative.
    send_frame(24'hFFFFFB, 24'h000001, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("pk_left_1", 64'(peak_left), 64'd5);
    send_frame(24'h000003, 24'h000002, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("pk_left_2", 64'(peak_left), 64'd5);
    send_frame(24'h800000, 24'h000003, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("pk_left_3", 64'(peak_left), 64'h7FFFFF);
    check("pk_right_3", 64'(peak_right), 64'd3);
    peak_clear = 1'b1;
    @(negedge clk);
    peak_clear = 1'b0;
    check("pk_clear_left", 64'(peak_left), 64'd0);
    check("pk_clear_right", 64'(peak_right), 64'd0);
`endif

    repeat (20) @(negedge clk);
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
